// File: rtl/upper_imm_extractor.sv
// upper_imm_extractor
// Extracts a 16-bit upper immediate from a 32-bit packed word by
// logically right-shifting it SHAMT places, one bit per clock.
//
// Optional feature macro: UPPER_IMM_LOWCHK_EN
//   defined   : err reports whether any bit shifted out was nonzero
//   undefined : err is tied low and the discard accumulator is not built
//
// Handshake: out_valid is high for the whole DONE state. The result is
// transferred on a rising edge where out_valid and out_ready are both high.
// out_imm and err stay constant while out_valid is high. start is only
// looked at in IDLE. Any start seen in SHIFT or DONE is dropped, never queued.
module upper_imm_extractor #(
    parameter int SHAMT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in_word,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic        err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter value present during the final shift. The counter tops out
    // at SHAMT (at most 16), so 5 bits never wrap.
    localparam logic [4:0] LAST_CNT = 5'(SHAMT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] work_q;
    logic [4:0]  cnt_q;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)             state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // State register. Reset takes priority over start and out_ready.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Work register and shift counter.
    // In IDLE, start captures the input word. Later changes to in_word
    // have no effect on this job.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= 32'h0;
            cnt_q  <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q <= in_word;
                        cnt_q  <= 5'd0;
                    end
                end
                SHIFT: begin
                    work_q <= {1'b0, work_q[31:1]};
                    cnt_q  <= cnt_q + 5'd1;
                end
                default: begin
                    work_q <= work_q;
                    cnt_q  <= cnt_q;
                end
            endcase
        end
    end

`ifdef UPPER_IMM_LOWCHK_EN
    logic acc_q;

    // Accumulate every bit that falls off the bottom of the work register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (start) acc_q <= 1'b0;
                SHIFT:   acc_q <= acc_q | work_q[0];
                default: acc_q <= acc_q;
            endcase
        end
    end

    assign err = acc_q;
`else
    assign err = 1'b0;
`endif

    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign out_imm   = work_q[15:0];
    assign state_dbg = state_q;

endmodule
